axi_single_master: RTL and testbench

//  Single-outstanding AXI4 initiator. Turns a simple valid/ready request port into one-beat AXI4

---
 rtl/axi_pkg.sv | 13 +
 rtl/axi_single_master_if.sv | 58 +++++
 rtl/axi_mst_watchdog.sv | 24 ++
 rtl/axi_single_master.sv | 197 +++++++++++++++++++
 tb/tb_axi_single_master.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: AXI response/burst codes and the initiator FSM state encoding.
//   Shared by axi_single_master, axi_mst_watchdog users and the bench.
package axi_pkg;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_BW, ST_RD, ST_RW, ST_RSP} mst_state_e;
    function automatic logic is_busy(mst_state_e s);
        return s inside {ST_WR, ST_BW, ST_RD, ST_RW};
    endfunction
endpackage

// File: rtl/axi_single_master_if.sv
// axi_single_master_if: AXI4 bus bundle between one initiator and one target.
//   Parameters ADDR_W/ID_W/DATA_W size the address, ID and data fields.
//   modport master: drives AW/W/AR payload+valid, bready, rready.
//   modport slave : drives awready/wready/arready, B and R channels.
interface axi_single_master_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    parameter int DATA_W = 64
);
    logic              awvalid, awready, awlock;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize, awprot;
    logic [1:0]        awburst;
    logic [3:0]        awcache, awqos, awregion;
    logic [ID_W-1:0]   awid;
    logic                wvalid, wready, wlast;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic            bvalid, bready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic              arvalid, arready, arlock;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize, arprot;
    logic [1:0]        arburst;
    logic [3:0]        arcache, arqos, arregion;
    logic [ID_W-1:0]   arid;
    logic              rvalid, rready, rlast;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;
    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arid,
        input  arready,
        input  rvalid, rid, rresp, rdata, rlast,
        output rready
    );
    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arid,
        output arready,
        output rvalid, rid, rresp, rdata, rlast,
        input  rready
    );
endinterface

// File: rtl/axi_mst_watchdog.sv
// axi_mst_watchdog: cycle counter that flags a transaction stuck for TIMEOUT cycles.
//   clk, rst : clock, synchronous active-high reset
//   clear    : hold the count at zero (initiator not busy)
//   run      : count one per cycle
//   expire   : run is high and the count has reached TIMEOUT-1
module axi_mst_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);
    logic [15:0] cnt;
    assign expire = run && cnt >= 16'(TIMEOUT - 1);
    // Saturates at the limit so a partial handshake on the expiry cycle cannot wrap it.
    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (run && !expire)
            cnt <= cnt + 16'd1;
    end
endmodule

// File: rtl/axi_single_master.sv
// axi_single_master: single-outstanding AXI4 initiator turning a valid/ready request
//   into one-beat reads/writes and returning the response on a valid/ready port.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake; req_write/addr/size/wdata/wstrb captured on accept
//   rsp_valid/rsp_ready      : response handshake; rsp_resp, rsp_rdata (0 for writes)
//   axi (master modport)     : AXI4 AW/W/B/AR/R channels
//   Optional macro AXI_MST_TIMEOUT_EN adds a TIMEOUT-cycle watchdog that answers DECERR
//   and then refuses further requests until reset.
module axi_single_master
    import axi_pkg::*;
#(
    parameter int                AXI_ADDR_W = 32,
    parameter int                AXI_ID_W   = 8,
    parameter int                AXI_DATA_W = 64,
    parameter logic [AXI_ID_W-1:0] AXI_ID   = '0,
    parameter int                TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [AXI_ADDR_W-1:0]   req_addr,
    input  logic [2:0]              req_size,
    input  logic [AXI_DATA_W-1:0]   req_wdata,
    input  logic [AXI_DATA_W/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_resp,
    output logic [AXI_DATA_W-1:0]   rsp_rdata,
    axi_single_master_if.master     axi
);
    mst_state_e state, state_d;
    logic [AXI_ADDR_W-1:0]   addr, addr_d;
    logic [2:0]              size, size_d;
    logic [AXI_DATA_W-1:0]   wdata, wdata_d, rsp_rdata_d;
    logic [AXI_DATA_W/8-1:0] wstrb, wstrb_d;
    logic awvalid, wvalid, arvalid, bready, rready, dead;
    logic awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d, dead_d, rsp_valid_d;
    logic [1:0] rsp_resp_d;
    logic hs, expire;
`ifdef AXI_MST_TIMEOUT_EN
    axi_mst_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!is_busy(state)),
        .run    (is_busy(state)),
        .expire (expire)
    );
`else
    logic unused;
    assign expire = 1'b0;
    assign unused = ^{axi.bid, axi.rid, axi.rlast, 32'(TIMEOUT)};
`endif
`ifdef AXI_MST_TIMEOUT_EN
    logic unused;
    assign unused = ^{axi.bid, axi.rid, axi.rlast};
`endif
    assign req_ready    = state == ST_IDLE && !dead;
    assign axi.awvalid  = awvalid;
    assign axi.awaddr   = addr;
    assign axi.awlen    = '0;
    assign axi.awsize   = size;
    assign axi.awburst  = AXI_BURST_INCR;
    assign axi.awlock   = 1'b0;
    assign axi.awcache  = '0;
    assign axi.awprot   = '0;
    assign axi.awqos    = '0;
    assign axi.awregion = '0;
    assign axi.awid     = AXI_ID;
    assign axi.wvalid   = wvalid;
    assign axi.wdata    = wdata;
    assign axi.wstrb    = wstrb;
    assign axi.wlast    = 1'b1;
    assign axi.bready   = bready;
    assign axi.arvalid  = arvalid;
    assign axi.araddr   = addr;
    assign axi.arlen    = '0;
    assign axi.arsize   = size;
    assign axi.arburst  = AXI_BURST_INCR;
    assign axi.arlock   = 1'b0;
    assign axi.arcache  = '0;
    assign axi.arprot   = '0;
    assign axi.arqos    = '0;
    assign axi.arregion = '0;
    assign axi.arid     = AXI_ID;
    assign axi.rready   = rready;
    always_comb begin
        state_d     = state;
        addr_d      = addr;
        size_d      = size;
        wdata_d     = wdata;
        wstrb_d     = wstrb;
        awvalid_d   = awvalid;
        wvalid_d    = wvalid;
        arvalid_d   = arvalid;
        bready_d    = bready;
        rready_d    = rready;
        rsp_valid_d = rsp_valid;
        rsp_resp_d  = rsp_resp;
        rsp_rdata_d = rsp_rdata;
        dead_d      = dead;
        hs = (awvalid & axi.awready) | (wvalid & axi.wready) | (arvalid & axi.arready) |
             (bready & axi.bvalid) | (rready & axi.rvalid);
        case (state)
            ST_IDLE: if (req_valid && req_ready) begin
                state_d   = req_write ? ST_WR : ST_RD;
                addr_d    = req_addr;
                size_d    = req_size;
                wdata_d   = req_wdata;
                wstrb_d   = req_wstrb;
                awvalid_d = req_write;
                wvalid_d  = req_write;
                arvalid_d = !req_write;
            end
            // AW and W retire independently; BW once neither is still pending.
            ST_WR: begin
                awvalid_d = awvalid & ~axi.awready;
                wvalid_d  = wvalid & ~axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_BW;
                    bready_d = 1'b1;
                end
            end
            ST_BW: if (axi.bvalid) begin
                state_d     = ST_RSP;
                bready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_resp_d  = axi.bresp;
                rsp_rdata_d = '0;
            end
            ST_RD: if (axi.arready) begin
                state_d   = ST_RW;
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
            end
            ST_RW: if (axi.rvalid) begin
                state_d     = ST_RSP;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_resp_d  = axi.rresp;
                rsp_rdata_d = axi.rdata;
            end
            ST_RSP: if (rsp_ready) begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        // A handshake on the expiry cycle wins; the stuck transaction is abandoned otherwise.
        if (expire && !hs) begin
            state_d     = ST_RSP;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            bready_d    = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_resp_d  = AXI_RESP_DECERR;
            rsp_rdata_d = '0;
            dead_d      = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            size      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            arvalid   <= 1'b0;
            bready    <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_resp  <= AXI_RESP_OKAY;
            rsp_rdata <= '0;
            dead      <= 1'b0;
        end else begin
            state     <= state_d;
            addr      <= addr_d;
            size      <= size_d;
            wdata     <= wdata_d;
            wstrb     <= wstrb_d;
            awvalid   <= awvalid_d;
            wvalid    <= wvalid_d;
            arvalid   <= arvalid_d;
            bready    <= bready_d;
            rready    <= rready_d;
            rsp_valid <= rsp_valid_d;
            rsp_resp  <= rsp_resp_d;
            rsp_rdata <= rsp_rdata_d;
            dead      <= dead_d;
        end
    end
endmodule

// File: tb/tb_axi_single_master.sv
// tb_axi_single_master: table-driven, hand-written and random transactions against a
//   cycle-level AXI responder; expected responses come from a transaction-level model.
module tb_axi_single_master;
    import axi_pkg::*;
    localparam logic [7:0] TB_ID = 8'h3C;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_size = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic rsp_valid, rsp_ready = 1'b0;
    logic [1:0]  rsp_resp;
    logic [63:0] rsp_rdata;
    int checks = 0;
    int errors = 0;
    axi_single_master_if #(.ADDR_W(32), .ID_W(8), .DATA_W(64)) axi ();
    axi_single_master #(
        .AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_DATA_W(64), .AXI_ID(TB_ID), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
        .axi(axi)
    );
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [2:0]  size;
        int          a_dly;
        int          w_dly;
        int          d_dly;
        int          rsp_dly;
        logic [1:0]  resp;
        logic [63:0] rdata;
        logic [1:0]  exp_resp;
        logic [63:0] exp_rdata;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: writes return bresp with zero data, reads return R as-is.
    function automatic vec_t model(vec_t v);
        vec_t m = v;
        m.exp_resp  = v.resp;
        m.exp_rdata = v.wr ? 64'd0 : v.rdata;
        return m;
    endfunction

    function automatic logic [4:0] bus_ctl();
        return {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready};
    endfunction

    task automatic issue(input vec_t v);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_size  = v.size;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        axi.bresp = v.resp;
        axi.rresp = v.resp;
        axi.rdata = v.rdata;
        axi.bid   = 8'($urandom);
        axi.rid   = 8'($urandom);
        axi.rlast = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        bit a_done, w_done, d_done, ph_d, a_hs, w_hs, d_hs;
        int cyc, dcyc;
        chk("req_ready idle", req_ready, 1'b1);
        issue(v);
        a_done = 0; w_done = !v.wr; d_done = 0; cyc = 0; dcyc = 0;
        while (!d_done && cyc < 100) begin
            ph_d = a_done && w_done;
            chk("req_ready busy", req_ready, 1'b0);
            chk("rsp_valid busy", rsp_valid, 1'b0);
            if (v.wr) begin
                chk("awvalid", axi.awvalid, !a_done);
                if (!a_done)
                    chk("aw payload", {axi.awaddr, axi.awsize, axi.awlen, axi.awburst, axi.awid, axi.awlock,
                                       axi.awcache, axi.awprot, axi.awqos, axi.awregion},
                                      {v.addr, v.size, 8'd0, AXI_BURST_INCR, TB_ID, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
                chk("wvalid", axi.wvalid, !w_done);
                if (!w_done)
                    chk("w payload", {axi.wdata, axi.wstrb, axi.wlast}, {v.wdata, v.wstrb, 1'b1});
                chk("bready", axi.bready, ph_d);
                chk("read side idle", {axi.arvalid, axi.rready}, 2'b00);
                axi.awready = cyc >= v.a_dly;
                axi.wready  = cyc >= v.w_dly;
                axi.bvalid  = ph_d && dcyc >= v.d_dly;
                a_hs = !a_done && axi.awready;
                w_hs = !w_done && axi.wready;
                d_hs = ph_d && axi.bvalid;
            end else begin
                chk("arvalid", axi.arvalid, !a_done);
                if (!a_done)
                    chk("ar payload", {axi.araddr, axi.arsize, axi.arlen, axi.arburst, axi.arid, axi.arlock,
                                       axi.arcache, axi.arprot, axi.arqos, axi.arregion},
                                      {v.addr, v.size, 8'd0, AXI_BURST_INCR, TB_ID, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
                chk("rready", axi.rready, ph_d);
                chk("write side idle", {axi.awvalid, axi.wvalid, axi.bready}, 3'b000);
                axi.arready = cyc >= v.a_dly;
                axi.rvalid  = ph_d && dcyc >= v.d_dly;
                a_hs = !a_done && axi.arready;
                w_hs = 0;
                d_hs = ph_d && axi.rvalid;
            end
            step();
            if (a_hs) a_done = 1;
            if (w_hs) w_done = 1;
            if (d_hs) d_done = 1;
            if (ph_d) dcyc++;
            cyc++;
        end
        {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid} = '0;
        if (!d_done) chk("txn cycle budget", 1'b0, 1'b1);
        for (int i = 0; i <= v.rsp_dly; i++) begin
            rsp_ready = (i == v.rsp_dly);
            chk("rsp_valid held", rsp_valid, 1'b1);
            chk("rsp payload", {rsp_resp, rsp_rdata}, {v.exp_resp, v.exp_rdata});
            chk("req_ready in rsp", req_ready, 1'b0);
            chk("bus quiet in rsp", bus_ctl(), 5'b0);
            step();
        end
        rsp_ready = 1'b0;
        chk("rsp_valid after hs", rsp_valid, 1'b0);
        chk("req_ready after rsp", req_ready, 1'b1);
    endtask

    vec_t tbl[6];
    vec_t v;

    initial begin
        tbl[0] = '{1'b1, 32'h0200_4000, 64'h1122_3344_5566_7788, 8'hFF, 3'd3, 0, 0, 0, 0,
                   AXI_RESP_OKAY, 64'hAAAA_5555_AAAA_5555, 2'd0, 64'd0};
        tbl[1] = '{1'b0, 32'h0200_BFF8, 64'd0, 8'h00, 3'd3, 3, 0, 2, 0,
                   AXI_RESP_OKAY, 64'hDEAD_BEEF_0000_0001, 2'd0, 64'hDEAD_BEEF_0000_0001};
        tbl[2] = '{1'b1, 32'h0200_4008, 64'hCAFE_F00D_1234_5678, 8'hF0, 3'd3, 4, 0, 1, 0,
                   AXI_RESP_OKAY, 64'h1234, 2'd0, 64'd0};
        tbl[3] = '{1'b1, 32'h0200_4010, 64'h0BAD_C0DE_8765_4321, 8'h0F, 3'd2, 0, 3, 0, 1,
                   AXI_RESP_EXOKAY, 64'h5678, 2'd1, 64'd0};
        tbl[4] = '{1'b0, 32'h1000_0000, 64'd0, 8'h00, 3'd2, 1, 0, 0, 5,
                   AXI_RESP_SLVERR, 64'h0123_4567_89AB_CDEF, 2'd2, 64'h0123_4567_89AB_CDEF};
        tbl[5] = '{1'b1, 32'h0000_0004, 64'h0000_0000_7777_7777, 8'h0F, 3'd2, 2, 2, 3, 0,
                   AXI_RESP_DECERR, 64'hFFFF, 2'd3, 64'd0};
        {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, axi.rlast} = '0;
        axi.bid = '0; axi.rid = '0; axi.bresp = '0; axi.rresp = '0; axi.rdata = '0;
        repeat (3) step();
        chk("reset bus ctl", bus_ctl(), 5'b0);
        chk("reset rsp", {rsp_valid, rsp_resp, rsp_rdata}, '0);
        rst = 1'b0;
        chk("req_ready after reset", req_ready, 1'b1);
        step();
        chk("idle bus ctl", bus_ctl(), 5'b0);
        foreach (tbl[i]) run_txn(tbl[i]);
        // Reset while waiting for R after the AR handshake.
        v = '{1'b0, 32'h0000_0100, 64'd0, 8'h00, 3'd3, 0, 0, 0, 0, AXI_RESP_OKAY, 64'h99, 2'd0, 64'h99};
        issue(v);
        chk("arvalid before rst", axi.arvalid, 1'b1);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        chk("rready in RW", axi.rready, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid-rst bus ctl", bus_ctl(), 5'b0);
        chk("mid-rst rsp_valid", rsp_valid, 1'b0);
        chk("mid-rst req_ready", req_ready, 1'b1);
        for (int n = 0; n < 40; n++) begin
            v.wr      = 1'($urandom);
            v.addr    = $urandom;
            v.wdata   = {$urandom, $urandom};
            v.wstrb   = 8'($urandom);
            v.size    = 3'($urandom_range(0, 3));
            v.a_dly   = $urandom_range(0, 4);
            v.w_dly   = $urandom_range(0, 4);
            v.d_dly   = $urandom_range(0, 4);
            v.rsp_dly = $urandom_range(0, 3);
            v.resp    = 2'($urandom);
            v.rdata   = {$urandom, $urandom};
            run_txn(model(v));
        end
`ifdef AXI_MST_TIMEOUT_EN
        v = '{1'b1, 32'h0200_0000, 64'h5, 8'hFF, 3'd3, 0, 0, 0, 0, AXI_RESP_OKAY, 64'd7, 2'd0, 64'd0};
        issue(v);
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("no rsp before timeout", rsp_valid, 1'b0);
            step();
        end
        {axi.awready, axi.wready} = '0;
        chk("timeout rsp", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, AXI_RESP_DECERR, 64'd0});
        chk("timeout bus ctl", bus_ctl(), 5'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("dead req_ready", req_ready, 1'b0);
            step();
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
